// File: rtl/mac_vec_array.sv
// Multi-lane multiply-accumulate engine: NUM_LANES lanes multiply their own A operand by a
// broadcast B operand each accepted beat and accumulate over VEC_LEN beats.
module mac_vec_array #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int VEC_LEN    = 8,
  parameter int SATURATE   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            signed_mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0]           b_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*ACC_WIDTH-1:0]  acc_out,
  output logic [NUM_LANES-1:0]            ovf
);

  localparam int CW = $clog2(VEC_LEN+1);
  localparam int PW = 2*DATA_WIDTH;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic                 pv;
  logic                 pmode;
  logic [PW-1:0]        prod_q [NUM_LANES];
  logic [PW-1:0]        prod_d [NUM_LANES];
  logic [ACC_WIDTH-1:0] acc_q  [NUM_LANES];
  logic [ACC_WIDTH-1:0] acc_d  [NUM_LANES];
  logic [NUM_LANES-1:0] ovf_q;
  logic [NUM_LANES-1:0] ovf_d;
  logic                 accept;

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign ovf       = ovf_q;

  // Operands are extended to the full product width so the low PW bits are exact in either mode.
  always_comb begin
    logic [DATA_WIDTH-1:0] a;
    logic [PW-1:0]         ax;
    logic [PW-1:0]         bx;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      a = a_in[i*DATA_WIDTH +: DATA_WIDTH];
      if (signed_mode) begin
        ax = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        bx = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
      end else begin
        ax = {{DATA_WIDTH{1'b0}}, a};
        bx = {{DATA_WIDTH{1'b0}}, b_in};
      end
      prod_d[i] = ax * bx;
    end
  end

  // One guard bit above the accumulator exposes overflow in both modes.
  always_comb begin
    logic [ACC_WIDTH:0]   ext;
    logic [ACC_WIDTH:0]   accx;
    logic [ACC_WIDTH:0]   sum;
    logic                 over;
    logic [ACC_WIDTH-1:0] sat;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      acc_d[i] = acc_q[i];
      ovf_d[i] = ovf_q[i];
      if (pmode) begin
        ext  = {{(ACC_WIDTH+1-PW){prod_q[i][PW-1]}}, prod_q[i]};
        accx = {acc_q[i][ACC_WIDTH-1], acc_q[i]};
      end else begin
        ext  = {{(ACC_WIDTH+1-PW){1'b0}}, prod_q[i]};
        accx = {1'b0, acc_q[i]};
      end
      sum  = accx + ext;
      over = pmode ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
      if (!pmode)
        sat = '1;
      else if (sum[ACC_WIDTH])
        sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      if (pv) begin
        acc_d[i] = (over && SATURATE != 0) ? sat : sum[ACC_WIDTH-1:0];
        ovf_d[i] = ovf_q[i] | over;
      end
    end
  end

  always_comb begin
    acc_out = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++)
      acc_out[i*ACC_WIDTH +: ACC_WIDTH] = acc_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
      cnt   <= '0;
      pv    <= 1'b0;
      pmode <= 1'b0;
      ovf_q <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else if (clr) begin
      state <= ST_ACC;
      cnt   <= '0;
      pv    <= 1'b0;
      ovf_q <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++)
        acc_q[i] <= '0;
    end else begin
      pv    <= accept;
      ovf_q <= ovf_d;
      for (int unsigned i = 0; i < NUM_LANES; i++)
        acc_q[i] <= acc_d[i];
      if (accept) begin
        pmode <= signed_mode;
        for (int unsigned i = 0; i < NUM_LANES; i++)
          prod_q[i] <= prod_d[i];
      end
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (cnt == CW'(VEC_LEN-1)) begin
              cnt   <= '0;
              state <= ST_DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_ACC;
            ovf_q <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++)
              acc_q[i] <= '0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
